// File: rtl/blink_interval_ctrl_if.sv
// Button inputs and interval outputs of the blink interval controller.
// The slave side is the controller; the master side drives the buttons.
interface blink_interval_ctrl_if;
    logic        btn_up;
    logic        btn_dn;
    logic [15:0] interval_ms;
    logic        update;
    logic        at_limit;

    modport master (
        output btn_up,
        output btn_dn,
        input  interval_ms,
        input  update,
        input  at_limit
    );

    modport slave (
        input  btn_up,
        input  btn_dn,
        output interval_ms,
        output update,
        output at_limit
    );
endinterface

// File: rtl/blink_interval_ctrl.sv
// Up/down pushbutton front end for the LED blinker: synchronise, debounce,
// step on press, auto-repeat on hold, saturate, and chord back to default.
module blink_interval_ctrl #(
    parameter int unsigned DEFAULT_MS   = 500,
    parameter int unsigned MIN_MS       = 50,
    parameter int unsigned MAX_MS       = 2000,
    parameter int unsigned STEP_MS      = 50,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned HOLD_CYC     = 50000000,
    parameter int unsigned REPEAT_CYC   = 10000000
) (
    input  logic                   clk,
    input  logic                   rst,
    blink_interval_ctrl_if.slave   bus
);

    localparam int unsigned DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned TM_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYC - 1);
    localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REPEAT_CYC - 1);

    localparam logic [15:0] DEF16  = 16'(DEFAULT_MS);
    localparam logic [15:0] MIN16  = 16'(MIN_MS);
    localparam logic [15:0] MAX16  = 16'(MAX_MS);
    localparam logic [16:0] MIN17  = 17'(MIN_MS);
    localparam logic [16:0] MAX17  = 17'(MAX_MS);
    localparam logic [16:0] STEP17 = 17'(STEP_MS);
    localparam logic        AT_LIMIT_RST = (DEFAULT_MS == MIN_MS) || (DEFAULT_MS == MAX_MS);

    if (!((MIN_MS <= DEFAULT_MS) && (DEFAULT_MS <= MAX_MS) && (MAX_MS <= 65535) &&
          (STEP_MS >= 1) && (STEP_MS <= 65535) && (DEBOUNCE_CYC >= 1) &&
          (HOLD_CYC >= 1) && (REPEAT_CYC >= 1))) begin : g_param_check
        $error("blink_interval_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        CHORD  = 2'd3
    } state_t;

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]      meta_q, meta_d, sync_q, sync_d;
    logic [1:0]      lvl_q, lvl_d, prev_q, prev_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [1:0]      rise;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic [TM_W-1:0] timer_last;
    logic [15:0]     interval_q, interval_d, next_val;
    logic            update_q, update_d;
    logic            at_limit_q, at_limit_d;

    // Saturating step evaluated at 17 bits so neither direction can wrap.
    function automatic logic [15:0] step_val(input logic [15:0] cur, input logic down);
        logic [16:0] cur17;
        logic [16:0] res17;
        cur17 = {1'b0, cur};
        if (down) begin
            res17 = cur17 - STEP17;
            if (cur17 < (MIN17 + STEP17)) begin
                step_val = MIN16;
            end else begin
                step_val = res17[15:0];
            end
        end else begin
            res17 = cur17 + STEP17;
            if (res17 > MAX17) begin
                step_val = MAX16;
            end else begin
                step_val = res17[15:0];
            end
        end
    endfunction

    always_comb begin
        meta_d = {bus.btn_dn, bus.btn_up};
        sync_d = meta_q;
        prev_d = lvl_q;
        lvl_d  = lvl_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = DB_W'(0);
            if (sync_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end else begin
                cnt_d[i] = DB_W'(0);
            end
        end
    end

    assign rise = lvl_q & ~prev_q;

    // Release beats chord, chord beats timer expiry while a button is held.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        next_val = interval_q;
        if (state_q == HOLD) begin
            timer_last = HOLD_LAST;
        end else begin
            timer_last = REP_LAST;
        end
        case (state_q)
            IDLE: begin
                timer_d = TM_W'(0);
                if (lvl_q == 2'b11) begin
                    next_val = DEF16;
                    state_d  = CHORD;
                end else if (rise[0]) begin
                    next_val = step_val(interval_q, 1'b0);
                    dir_d    = 1'b0;
                    state_d  = HOLD;
                end else if (rise[1]) begin
                    next_val = step_val(interval_q, 1'b1);
                    dir_d    = 1'b1;
                    state_d  = HOLD;
                end else begin
                    state_d  = IDLE;
                end
            end
            HOLD, REPEAT: begin
                if (!lvl_q[dir_q]) begin
                    state_d = IDLE;
                    timer_d = TM_W'(0);
                end else if (lvl_q[~dir_q]) begin
                    next_val = DEF16;
                    state_d  = CHORD;
                    timer_d  = TM_W'(0);
                end else if (timer_q == timer_last) begin
                    next_val = step_val(interval_q, dir_q);
                    state_d  = REPEAT;
                    timer_d  = TM_W'(0);
                end else begin
                    timer_d  = timer_q + TM_W'(1);
                end
            end
            CHORD: begin
                timer_d = TM_W'(0);
                if (lvl_q == 2'b00) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHORD;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = TM_W'(0);
            end
        endcase
        interval_d = next_val;
        update_d   = (next_val != interval_q);
        at_limit_d = (next_val == MIN16) || (next_val == MAX16);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= 2'b00;
            sync_q     <= 2'b00;
            lvl_q      <= 2'b00;
            prev_q     <= 2'b00;
            cnt_q[0]   <= DB_W'(0);
            cnt_q[1]   <= DB_W'(0);
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            timer_q    <= TM_W'(0);
            interval_q <= DEF16;
            update_q   <= 1'b0;
            at_limit_q <= AT_LIMIT_RST;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            lvl_q      <= lvl_d;
            prev_q     <= prev_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            state_q    <= state_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            interval_q <= interval_d;
            update_q   <= update_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign bus.interval_ms = interval_q;
    assign bus.update      = update_q;
    assign bus.at_limit    = at_limit_q;

endmodule

// File: tb/tb_blink_interval_ctrl.sv
// Directed bench for blink_interval_ctrl: a per-cycle behavioural model plus
// hand-computed checkpoints for press, bounce, repeat, saturation and chord.
module tb_blink_interval_ctrl;

    localparam int DEF  = 100;
    localparam int MINV = 50;
    localparam int MAXV = 200;
    localparam int STEP = 50;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   upd_cnt = 0;
    int   base;
    bit   run_chk = 1'b0;

    blink_interval_ctrl_if bus_if ();

    blink_interval_ctrl #(
        .DEFAULT_MS  (DEF),
        .MIN_MS      (MINV),
        .MAX_MS      (MAXV),
        .STEP_MS     (STEP),
        .DEBOUNCE_CYC(DB),
        .HOLD_CYC    (HOLD),
        .REPEAT_CYC  (REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int up_step(input int v);
        return (v + STEP > MAXV) ? MAXV : v + STEP;
    endfunction

    function automatic int dn_step(input int v);
        return (v - STEP < MINV) ? MINV : v - STEP;
    endfunction

    function automatic bit all_differ(input bit q[$], input bit lvl);
        if (q.size() < DB) return 1'b0;
        foreach (q[k]) if (q[k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural model: state after each clock edge.
    int     m_int;
    bit     m_upd;
    int     m_mode;   // 0 released, 1 one button held, 2 chord
    bit     m_dir;
    int     m_age;    // edges spent held since the first step
    bit [1:0] m_lvl, m_prev, m_s1, m_s2;
    bit     hu[$];
    bit     hd[$];
    int     nxt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_int = DEF; m_upd = 1'b0; m_mode = 0; m_dir = 1'b0; m_age = 0;
            m_lvl = 2'b00; m_prev = 2'b00; m_s1 = 2'b00; m_s2 = 2'b00;
            hu.delete(); hd.delete();
        end else begin
            nxt = m_int;
            if (m_mode == 0) begin
                if (m_lvl == 2'b11) begin
                    nxt = DEF; m_mode = 2;
                end else if (m_lvl[0] && !m_prev[0]) begin
                    nxt = up_step(m_int); m_dir = 1'b0; m_mode = 1; m_age = 0;
                end else if (m_lvl[1] && !m_prev[1]) begin
                    nxt = dn_step(m_int); m_dir = 1'b1; m_mode = 1; m_age = 0;
                end
            end else if (m_mode == 1) begin
                if (!m_lvl[m_dir]) begin
                    m_mode = 0;
                end else if (m_lvl[!m_dir]) begin
                    nxt = DEF; m_mode = 2;
                end else begin
                    m_age++;
                    if (m_age >= HOLD && ((m_age - HOLD) % REP) == 0)
                        nxt = m_dir ? dn_step(m_int) : up_step(m_int);
                end
            end else begin
                if (m_lvl == 2'b00) m_mode = 0;
            end
            m_upd  = (nxt != m_int);
            m_int  = nxt;
            m_prev = m_lvl;
            hu.push_back(m_s2[0]); if (hu.size() > DB) void'(hu.pop_front());
            hd.push_back(m_s2[1]); if (hd.size() > DB) void'(hd.pop_front());
            if (all_differ(hu, m_lvl[0])) begin m_lvl[0] = ~m_lvl[0]; hu.delete(); end
            if (all_differ(hd, m_lvl[1])) begin m_lvl[1] = ~m_lvl[1]; hd.delete(); end
            m_s2 = m_s1;
            m_s1 = {bus_if.btn_dn, bus_if.btn_up};
        end
    end

    always @(negedge clk) begin
        if (run_chk && !rst) begin
            check("model interval_ms", int'(bus_if.interval_ms), m_int);
            check("model update", int'(bus_if.update), int'(m_upd));
            check("model at_limit", int'(bus_if.at_limit), (m_int == MINV || m_int == MAXV) ? 1 : 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (bus_if.update === 1'b1) upd_cnt++;
    end

    initial begin
        bus_if.btn_up = 1'b0;
        bus_if.btn_dn = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        run_chk = 1'b1;
        check("reset interval", int'(bus_if.interval_ms), 100);
        check("reset update", int'(bus_if.update), 0);
        check("reset at_limit", int'(bus_if.at_limit), 0);

        // single press
        base = upd_cnt;
        bus_if.btn_up = 1'b1;
        tick(6);
        check("press before latency", int'(bus_if.interval_ms), 100);
        tick(1);
        check("press after 7 cycles", int'(bus_if.interval_ms), 150);
        check("press update pulse", int'(bus_if.update), 1);
        tick(3);
        bus_if.btn_up = 1'b0;
        tick(15);
        check("press final value", int'(bus_if.interval_ms), 150);
        check("press pulse count", upd_cnt - base, 1);

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async reset interval", int'(bus_if.interval_ms), 100);
        check("async reset update", int'(bus_if.update), 0);
        check("async reset at_limit", int'(bus_if.at_limit), 0);
        @(negedge clk);
        rst = 1'b0;

        // bounce on btn_dn
        base = upd_cnt;
        for (int i = 0; i < 10; i++) begin
            bus_if.btn_dn = ((i % 2) == 0);
            tick(2);
        end
        bus_if.btn_dn = 1'b0;
        tick(15);
        check("bounce value", int'(bus_if.interval_ms), 100);
        check("bounce pulse count", upd_cnt - base, 0);

        // hold up with repeat and saturation
        base = upd_cnt;
        bus_if.btn_up = 1'b1;
        tick(7);
        check("hold first step", int'(bus_if.interval_ms), 150);
        tick(20);
        check("hold second step", int'(bus_if.interval_ms), 200);
        check("hold at_limit", int'(bus_if.at_limit), 1);
        tick(33);
        bus_if.btn_up = 1'b0;
        tick(15);
        check("hold final value", int'(bus_if.interval_ms), 200);
        check("hold pulse count", upd_cnt - base, 2);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // saturate low
        base = upd_cnt;
        for (int p = 0; p < 3; p++) begin
            bus_if.btn_dn = 1'b1;
            tick(7);
            check("sat-low step", int'(bus_if.interval_ms), 50);
            tick(3);
            bus_if.btn_dn = 1'b0;
            tick(10);
        end
        tick(5);
        check("sat-low at_limit", int'(bus_if.at_limit), 1);
        check("sat-low pulse count", upd_cnt - base, 1);

        // chord during repeat, starting from 50
        base = upd_cnt;
        bus_if.btn_up = 1'b1;
        tick(7);
        check("chord-run first step", int'(bus_if.interval_ms), 100);
        tick(15);
        bus_if.btn_dn = 1'b1;
        tick(5);
        check("chord-run repeat entry", int'(bus_if.interval_ms), 150);
        tick(2);
        check("chord load", int'(bus_if.interval_ms), 100);
        check("chord update", int'(bus_if.update), 1);
        tick(3);
        bus_if.btn_dn = 1'b0;
        tick(40);
        check("chord held no step", int'(bus_if.interval_ms), 100);
        bus_if.btn_up = 1'b0;
        tick(15);
        check("chord released value", int'(bus_if.interval_ms), 100);
        check("chord pulse count", upd_cnt - base, 3);
        bus_if.btn_up = 1'b1;
        tick(7);
        check("fresh press after chord", int'(bus_if.interval_ms), 150);
        tick(3);
        bus_if.btn_up = 1'b0;
        tick(15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blink_interval_ctrl.md
Name: blink_interval_ctrl

Overview:
- Upstream control stage for the LED blinker.
- Turns two raw pushbuttons (up/down) into a registered 16-bit blink interval in milliseconds, `interval_ms`, which drives the blinker's `interval_ms` input directly.
- Provides synchronisation, debouncing, single-step on press, auto-repeat on hold, saturation at min/max, and a both-buttons chord that restores the default interval.

Parameters:
- DEFAULT_MS, 500: interval loaded at reset and on chord.
- MIN_MS, 50: lower saturation bound.
- MAX_MS, 2000: upper saturation bound.
- STEP_MS, 50: increment/decrement per step.
- DEBOUNCE_CYC, 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- HOLD_CYC, 50000000: cycles a single button must stay held after its first step before auto-repeat starts.
- REPEAT_CYC, 10000000: cycles between auto-repeat steps.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- btn_up, input, 1: raw pushbutton, asynchronous, active-high; increases the interval.
- btn_dn, input, 1: raw pushbutton, asynchronous, active-high; decreases the interval.
- interval_ms, output, 16: current interval in ms, registered.
- update, output, 1: one-cycle pulse in the first cycle `interval_ms` shows a new value.
- at_limit, output, 1: high while `interval_ms` equals MIN_MS or MAX_MS.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state on posedge clk with asynchronous active-high rst.
  - Reset values: interval_ms = DEFAULT_MS, update = 0, at_limit = (DEFAULT_MS == MIN_MS or DEFAULT_MS == MAX_MS).
  - Reset also clears synchroniser flops, debounced levels, debounce counters and the repeat timer, and puts the FSM in IDLE.
  - Reset asserted mid-operation aborts any hold/repeat immediately. After release, a button still physically held must be re-debounced and produces a fresh press.
- Parameter legality: MIN_MS <= DEFAULT_MS <= MAX_MS <= 65535; STEP_MS >= 1; all cycle counts >= 1. Illegal combinations are unsupported; an elaboration-time check is recommended.
- Synchroniser: 2-flop per button.
- Debounce (per button):
  - The debounced level toggles only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles.
  - Any cycle where they match clears the counter.
  - Glitches shorter than DEBOUNCE_CYC are ignored.
- Latency: a clean raw edge to the `interval_ms` change takes exactly 2 + DEBOUNCE_CYC + 1 cycles.
- Step arithmetic, evaluated at 17-bit width, no wrap-around:
  - Up: next = min(interval_ms + STEP_MS, MAX_MS).
  - Down: next = (interval_ms < MIN_MS + STEP_MS) ? MIN_MS : interval_ms - STEP_MS.
  - A step that leaves the value unchanged (already saturated) does not pulse `update`.
- FSM states: IDLE, HOLD, REPEAT, CHORD.
  - IDLE:
    - Both debounced levels high in the same cycle: load DEFAULT_MS, go to CHORD.
    - Only up rises: step up, clear timer, go to HOLD (dn is symmetric).
  - HOLD:
    - Timer counts while the active button stays high.
    - Active button released: go to IDLE.
    - Other button rises: load DEFAULT_MS, go to CHORD.
    - Timer reaches HOLD_CYC-1: step, clear timer, go to REPEAT.
  - REPEAT:
    - Timer reaches REPEAT_CYC-1: step, clear timer.
    - Release and other-button transitions are as in HOLD.
  - CHORD:
    - No steps.
    - Stays until both debounced levels are low, then goes to IDLE.
    - Releasing one button leaves the other in CHORD; it never steps.
  - Release and chord take priority over a timer expiry in the same cycle.
- Chord update pulse: a chord load pulses `update` only if the value changes.
- at_limit: derived from the `interval_ms` register, with no extra cycle of lag relative to `interval_ms`.

Test Plan:
- All tests use DEFAULT_MS=100, MIN_MS=50, MAX_MS=200, STEP_MS=50, DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5.
- Reset: assert rst mid-cycle with no clock edge -> interval_ms=100, update=0, at_limit=0 immediately.
- Single press: btn_up high 10 cycles, then low -> interval_ms 100->150 exactly 7 cycles after the edge; one update pulse; no further change.
- Bounce: btn_dn toggles every 2 cycles for 20 cycles, then settles low -> interval_ms stays 100, update never asserted.
- Hold/repeat with saturation: hold btn_up 60 cycles ->
  - 150 at the first step.
  - 200 twenty cycles later; at_limit=1.
  - Later repeats leave the value at 200 with no update pulses.
- Saturate low: from 100, press btn_dn three times (each 10 cycles, separated by 10 cycles) -> 50, 50, 50; only the first press pulses update; at_limit=1.
- Chord: while btn_up is in REPEAT at 150, raise btn_dn -> interval_ms=100, one update pulse. Then release btn_dn only and keep btn_up held 40 cycles -> no steps until both are released and up is pressed again.
